// File: rtl/picorv32_axil_pkg.sv
// Shared types and constants for the two-port PicoRV32 to AXI4-Lite arbiter.
package picorv32_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } axil_state_t;

    localparam logic [2:0] PROT_INSTR = 3'b100;
    localparam logic [2:0] PROT_DATA  = 3'b000;

    function automatic logic [2:0] prot_for(input logic instr);
        return instr ? PROT_INSTR : PROT_DATA;
    endfunction

endpackage

// File: rtl/picorv32_axil_arbiter_rr.sv
// Two-way round-robin grant; a tie goes to the requester opposite last_grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant;

    always_comb begin
        gnt_valid = |req;
        gnt_id    = req[1];
        if (req == 2'b11)
            gnt_id = ~last_grant;
    end

    // Reset to 1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn)
            last_grant <= 1'b1;
        else if (update && gnt_valid)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/picorv32_axil_arbiter.sv
// Shares one AXI4-Lite master between two PicoRV32 native requesters;
// sequences a full write (AW+W+B) or read (AR+R) per grant.
module picorv32_axil_arbiter
    import picorv32_axil_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    output logic        grant_id,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

    axil_state_t   state;
    logic          gnt_valid, gnt_id;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [3:0]    wstrb_q;
    logic          instr_q;
    logic [CW-1:0] wait_cnt;
    logic          leaving, waiting;
    logic [31:0]   sel_addr, sel_wdata;
    logic [3:0]    sel_wstrb;
    logic          sel_instr;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .resetn    (resetn),
        .req       ({m1_valid, m0_valid}),
        .update    (state == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        sel_addr  = gnt_id ? m1_addr  : m0_addr;
        sel_wdata = gnt_id ? m1_wdata : m0_wdata;
        sel_wstrb = gnt_id ? m1_wstrb : m0_wstrb;
        sel_instr = gnt_id ? m1_instr : m0_instr;
    end

    // leaving: the current state transitions at this edge.
    always_comb begin
        leaving = 1'b0;
        waiting = 1'b0;
        case (state)
            ST_IDLE:  leaving = gnt_valid;
            ST_WADDR: begin
                waiting = 1'b1;
                leaving = (!mem_axi_awvalid || mem_axi_awready) &&
                          (!mem_axi_wvalid  || mem_axi_wready);
            end
            ST_WRESP: begin waiting = 1'b1; leaving = mem_axi_bvalid;  end
            ST_RADDR: begin waiting = 1'b1; leaving = mem_axi_arready; end
            ST_RDATA: begin waiting = 1'b1; leaving = mem_axi_rvalid;  end
            default:  leaving = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            m0_ready        <= 1'b0;
            m1_ready        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            instr_q         <= 1'b0;
            rdata_q         <= '0;
            grant_id        <= 1'b0;
            timeout_err     <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                ST_IDLE: if (leaving) begin
                    addr_q   <= sel_addr;
                    wdata_q  <= sel_wdata;
                    wstrb_q  <= sel_wstrb;
                    instr_q  <= sel_instr;
                    grant_id <= gnt_id;
                    if (sel_wstrb != 4'd0) begin
                        state           <= ST_WADDR;
                        mem_axi_awvalid <= 1'b1;
                        mem_axi_wvalid  <= 1'b1;
                    end else begin
                        state           <= ST_RADDR;
                        mem_axi_arvalid <= 1'b1;
                    end
                end
                ST_WADDR: begin
                    if (mem_axi_awready) mem_axi_awvalid <= 1'b0;
                    if (mem_axi_wready)  mem_axi_wvalid  <= 1'b0;
                    if (leaving) begin
                        state          <= ST_WRESP;
                        mem_axi_bready <= 1'b1;
                    end
                end
                ST_WRESP: if (leaving) begin
                    state          <= ST_DONE;
                    mem_axi_bready <= 1'b0;
                    m0_ready       <= !grant_id;
                    m1_ready       <= grant_id;
                end
                ST_RADDR: if (leaving) begin
                    state           <= ST_RDATA;
                    mem_axi_arvalid <= 1'b0;
                    mem_axi_rready  <= 1'b1;
                end
                ST_RDATA: if (leaving) begin
                    state          <= ST_DONE;
                    mem_axi_rready <= 1'b0;
                    rdata_q        <= mem_axi_rdata;
                    m0_ready       <= !grant_id;
                    m1_ready       <= grant_id;
                end
                default: state <= ST_IDLE;
            endcase

            // Timeout only flags; AXI forbids withdrawing a raised valid.
            if (leaving || !waiting) begin
                wait_cnt <= '0;
            end else begin
                if (wait_cnt != TO_MAX)
                    wait_cnt <= wait_cnt + CW'(1);
                if (wait_cnt == TO_M1)
                    timeout_err <= 1'b1;
            end
        end
    end

    assign mem_axi_awaddr = addr_q;
    assign mem_axi_araddr = addr_q;
    assign mem_axi_wdata  = wdata_q;
    assign mem_axi_wstrb  = wstrb_q;
    assign mem_axi_awprot = prot_for(instr_q);
    assign mem_axi_arprot = prot_for(instr_q);
    assign m0_rdata       = rdata_q;
    assign m1_rdata       = rdata_q;

endmodule

// File: tb/tb_picorv32_axil_arbiter.sv
// Directed bench for picorv32_axil_arbiter with a small configurable AXI4-Lite slave.
module tb_picorv32_axil_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        grant_id, timeout_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    picorv32_axil_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
        .mem_axi_bready(bready), .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid),
        .mem_axi_rready(rready), .mem_axi_rdata(rdata),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    // Slave: knobs set by the stimulus, outputs changed on the falling edge.
    int          aw_delay, w_delay, ar_delay;
    logic        b_en, r_en;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [5:0]  ar_idx = '0;
    logic [31:0] mem [0:63];
    bit          wflag [0:63];
    int          b_hs = 0;

    always @(negedge clk) begin
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin arready = 1'b0; ar_cnt = 0; end
        bvalid = aw_pend && w_pend && b_en;
        rvalid = ar_pend && r_en;
        rdata  = wflag[ar_idx] ? mem[ar_idx] : (32'hA000_0000 | 32'(ar_idx));
    end

    always @(posedge clk) begin
        if (!resetn) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (awvalid && awready) aw_pend <= 1'b1;
            if (wvalid && wready)   w_pend  <= 1'b1;
            if (bvalid && bready) begin
                aw_pend <= 1'b0; w_pend <= 1'b0;
                b_hs <= b_hs + 1;
                mem[awaddr[7:2]]   <= wdata;
                wflag[awaddr[7:2]] <= 1'b1;
            end
            if (arvalid && arready) begin ar_pend <= 1'b1; ar_idx <= araddr[7:2]; end
            if (rvalid && rready)   ar_pend <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic instr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            m0_valid = v; m0_instr = instr; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_instr = instr; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    int b_before;

    initial begin
        resetn = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_en = 1'b1; r_en = 1'b1;
        tick(); tick();

        // reset state
        chk("rst_awvalid", 32'(awvalid), 32'h0);
        chk("rst_wvalid", 32'(wvalid), 32'h0);
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_bready", 32'(bready), 32'h0);
        chk("rst_rready", 32'(rready), 32'h0);
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'h0);
        chk("rst_rdata", m0_rdata, 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        resetn = 1'b1;
        tick();

        // m0 write, zero-wait slave
        drive(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        chk("wr_awvalid", 32'(awvalid), 32'h1);
        chk("wr_wvalid", 32'(wvalid), 32'h1);
        chk("wr_awaddr", awaddr, 32'h10);
        chk("wr_wdata", wdata, 32'hDEADBEEF);
        chk("wr_wstrb", 32'(wstrb), 32'hF);
        chk("wr_awprot", 32'(awprot), 32'h0);
        chk("wr_grant", 32'(grant_id), 32'h0);
        tick();
        chk("wr_aw_done", 32'({awvalid, wvalid}), 32'h0);
        chk("wr_bready", 32'(bready), 32'h1);
        chk("wr_early_ready", 32'(m0_ready), 32'h0);
        tick();
        chk("wr_m0_ready", 32'(m0_ready), 32'h1);
        chk("wr_m1_quiet", 32'(m1_ready), 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        chk("wr_ready_pulse", 32'(m0_ready), 32'h0);

        // m1 readback
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        chk("rb_arvalid", 32'(arvalid), 32'h1);
        chk("rb_araddr", araddr, 32'h10);
        chk("rb_grant", 32'(grant_id), 32'h1);
        tick();
        chk("rb_rready", 32'(rready), 32'h1);
        tick();
        chk("rb_m1_ready", 32'(m1_ready), 32'h1);
        chk("rb_m1_rdata", m1_rdata, 32'hDEADBEEF);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // ties right after reset
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        tick();
        chk("tie1_grant", 32'(grant_id), 32'h0);
        chk("tie1_araddr", araddr, 32'h20);
        tick(); tick();
        chk("tie1_m0_ready", 32'({m1_ready, m0_ready}), 32'h1);
        chk("tie1_m0_rdata", m0_rdata, 32'hA0000008);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        chk("tie1_grant_m1", 32'(grant_id), 32'h1);
        chk("tie1_araddr_m1", araddr, 32'h24);
        tick(); tick();
        chk("tie1_m1_ready", 32'({m1_ready, m0_ready}), 32'h2);
        chk("tie1_m1_rdata", m1_rdata, 32'hA0000009);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 32'h2C, 32'h0, 4'h0);
        tick();
        chk("tie2_grant", 32'(grant_id), 32'h0);
        tick(); tick();
        chk("tie2_m0_ready", 32'({m1_ready, m0_ready}), 32'h1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        chk("tie2_grant_m1", 32'(grant_id), 32'h1);
        tick(); tick();
        chk("tie2_m1_ready", 32'({m1_ready, m0_ready}), 32'h2);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // awready three cycles after wready
        aw_delay = 3;
        b_before = b_hs;
        drive(0, 1'b1, 1'b0, 32'h30, 32'h12345678, 4'h3);
        tick();
        chk("awd_both_valid", 32'({awvalid, wvalid}), 32'h3);
        tick();
        chk("awd_w_dropped", 32'({awvalid, wvalid}), 32'h2);
        tick();
        chk("awd_aw_held1", 32'({awvalid, wvalid}), 32'h2);
        chk("awd_wstrb", 32'(wstrb), 32'h3);
        tick();
        chk("awd_aw_held2", 32'({awvalid, wvalid}), 32'h2);
        tick();
        chk("awd_aw_done", 32'({awvalid, bready}), 32'h1);
        tick();
        chk("awd_m0_ready", 32'(m0_ready), 32'h1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        chk("awd_one_b", 32'(b_hs - b_before), 32'h1);
        aw_delay = 0;

        // instruction fetch from m1 with delayed arready
        ar_delay = 2;
        drive(1, 1'b1, 1'b1, 32'h100, 32'h0, 4'h0);
        tick();
        chk("if_arvalid", 32'(arvalid), 32'h1);
        chk("if_arprot", 32'(arprot), 32'h4);
        chk("if_araddr", araddr, 32'h100);
        tick();
        chk("if_ar_held1", 32'(arvalid), 32'h1);
        tick();
        chk("if_ar_held2", 32'(arvalid), 32'h1);
        chk("if_araddr_stable", araddr, 32'h100);
        tick();
        chk("if_ar_done", 32'({arvalid, rready}), 32'h1);
        tick();
        chk("if_m1_ready", 32'(m1_ready), 32'h1);
        chk("if_m1_rdata", m1_rdata, 32'hA0000000);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        ar_delay = 0;

        // slave never returns rvalid
        r_en = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        tick(); tick();
        chk("to_rready", 32'(rready), 32'h1);
        chk("to_err_start", 32'(timeout_err), 32'h0);
        repeat (14) tick();
        chk("to_err_before", 32'(timeout_err), 32'h0);
        tick();
        chk("to_err_set", 32'(timeout_err), 32'h1);
        chk("to_rready_held", 32'(rready), 32'h1);
        r_en = 1'b1;
        tick();
        chk("to_m0_ready", 32'(m0_ready), 32'h1);
        chk("to_m0_rdata", m0_rdata, 32'hA0000010);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        chk("to_err_sticky", 32'(timeout_err), 32'h1);

        // reset while in WRESP
        b_en = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h50, 32'hCAFEF00D, 4'hF);
        tick(); tick(); tick();
        chk("rw_in_wresp", 32'(bready), 32'h1);
        resetn = 1'b0;
        tick();
        chk("rw_bready", 32'(bready), 32'h0);
        chk("rw_valids", 32'({awvalid, wvalid, arvalid, rready}), 32'h0);
        chk("rw_ready", 32'({m1_ready, m0_ready}), 32'h0);
        chk("rw_timeout", 32'(timeout_err), 32'h0);
        chk("rw_awaddr", awaddr, 32'h0);
        chk("rw_wdata", wdata, 32'h0);
        chk("rw_wstrb", 32'(wstrb), 32'h0);
        chk("rw_grant", 32'(grant_id), 32'h0);
        resetn = 1'b1;
        b_en = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        drive(1, 1'b1, 1'b0, 32'h54, 32'h0BADF00D, 4'hF);
        tick();
        chk("rw2_grant", 32'(grant_id), 32'h1);
        chk("rw2_awaddr", awaddr, 32'h54);
        tick(); tick();
        chk("rw2_m1_ready", 32'({m1_ready, m0_ready}), 32'h2);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h54, 32'h0, 4'h0);
        tick(); tick(); tick();
        chk("rw2_m0_ready", 32'(m0_ready), 32'h1);
        chk("rw2_m0_rdata", m0_rdata, 32'h0BADF00D);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
